// File: rtl/ddsm_cfg_sync_pkg.sv
// ddsm_cfg_pkg: shared FSM type, counter sizing and reset constants for the DDSM config front-end
package ddsm_cfg_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, APPLY} state_e;
  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_BIT   = 1'b0;
  // Smallest width able to count 0..n-1, never below one bit
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/ddsm_cfg_sync_if.sv
// ddsm_cfg_sync_if: register-file side configuration bus of the DDSM config front-end
interface ddsm_cfg_sync_if #(
  parameter int SEED_W  = 12,
  parameter int ACC_W   = 8,
  parameter int MB_W    = 4,
  parameter int ORDER_W = 2
);
  logic               i_upd_req;
  logic [SEED_W-1:0]  i_seed;
  logic [ORDER_W-1:0] i_sel_order;
  logic [MB_W-1:0]    i_mash_bit;
  logic               i_mashreseten;
  logic               i_phaseadjusten;
  logic               i_sel_frac;
  logic [SEED_W-1:0]  o_seed;
  logic [ORDER_W-1:0] o_sel_order;
  logic               o_mashreseten;
  logic               o_phaseadjusten;
  logic               o_sel_frac;
  logic [ACC_W-1:0]   o_sum_sel;
  logic [ACC_W:0]     o_cout_sel;
  logic               o_cfg_err;
  logic               o_mash_rst;
  logic               o_busy;
  logic               o_upd_done;
  modport master (
    output i_upd_req, i_seed, i_sel_order, i_mash_bit, i_mashreseten, i_phaseadjusten, i_sel_frac,
    input  o_seed, o_sel_order, o_mashreseten, o_phaseadjusten, o_sel_frac,
           o_sum_sel, o_cout_sel, o_cfg_err, o_mash_rst, o_busy, o_upd_done
  );
  modport slave (
    input  i_upd_req, i_seed, i_sel_order, i_mash_bit, i_mashreseten, i_phaseadjusten, i_sel_frac,
    output o_seed, o_sel_order, o_mashreseten, o_phaseadjusten, o_sel_frac,
           o_sum_sel, o_cout_sel, o_cfg_err, o_mash_rst, o_busy, o_upd_done
  );
endinterface

// File: rtl/ddsm_cfg_sync_cdc_sync_bit.sv
// cdc_sync_bit: multi-flop single-bit synchroniser with async clear
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_ff_rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge i_clk or posedge i_ff_rst)
    if (i_ff_rst) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/ddsm_cfg_sync.sv
// ddsm_cfg_sync: synchronised atomic config capture with optional MASH flush and width decode
module ddsm_cfg_sync
  import ddsm_cfg_pkg::*;
#(
  parameter int SEED_W      = 12,
  parameter int ACC_W       = 8,
  parameter int MB_W        = 4,
  parameter int ORDER_W     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYC     = 4
) (
  input logic            i_clk,
  input logic            i_ff_rst,
  ddsm_cfg_sync_if.slave bus
);
  localparam int CW = cnt_w(RST_CYC);
  localparam logic [ACC_W:0] ONE = (ACC_W+1)'(1);
  state_e             state_q, state_d;
  logic               req_s, req_dly_q, rise;
  logic               pend_q, pend_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SEED_W-1:0]  sh_seed_q, sh_seed_d, seed_q, seed_d;
  logic [ORDER_W-1:0] sh_order_q, sh_order_d, order_q, order_d;
  logic [MB_W-1:0]    sh_mb_q, sh_mb_d, m;
  logic               sh_mr_q, sh_mr_d, mr_q, mr_d;
  logic               sh_pa_q, sh_pa_d, pa_q, pa_d;
  logic               sh_sf_q, sh_sf_d, sf_q, sf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [ACC_W:0]     cout_q, cout_d, cout;
  logic               err_q, err_d, over;
  logic               mrst_q, busy_q, done_q, done_d;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .i_clk(i_clk), .i_ff_rst(i_ff_rst), .d_i(bus.i_upd_req), .q_o(req_s)
  );
  assign rise = req_s & ~req_dly_q;

  // Oversized widths are clamped to the full accumulator and flagged
  assign over = sh_mb_q > MB_W'(ACC_W);
  assign m    = over ? MB_W'(ACC_W) : sh_mb_q;
  assign cout = ONE << m;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | rise;
    cnt_d      = '0;
    sh_seed_d  = sh_seed_q;
    sh_order_d = sh_order_q;
    sh_mb_d    = sh_mb_q;
    sh_mr_d    = sh_mr_q;
    sh_pa_d    = sh_pa_q;
    sh_sf_d    = sh_sf_q;
    seed_d     = seed_q;
    order_d    = order_q;
    mr_d       = mr_q;
    pa_d       = pa_q;
    sf_d       = sf_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (pend_q | rise) begin
        state_d = CAPTURE;
        pend_d  = 1'b0;
      end
      CAPTURE: begin
        sh_seed_d  = bus.i_seed;
        sh_order_d = bus.i_sel_order;
        sh_mb_d    = bus.i_mash_bit;
        sh_mr_d    = bus.i_mashreseten;
        sh_pa_d    = bus.i_phaseadjusten;
        sh_sf_d    = bus.i_sel_frac;
        state_d    = bus.i_mashreseten ? FLUSH : APPLY;
      end
      FLUSH: begin
        cnt_d   = (cnt_q == CW'(RST_CYC-1)) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q == CW'(RST_CYC-1)) ? APPLY : FLUSH;
      end
      APPLY: begin
        state_d = IDLE;
        seed_d  = sh_seed_q;
        order_d = sh_order_q;
        mr_d    = sh_mr_q;
        pa_d    = sh_pa_q;
        sf_d    = sh_sf_q;
        sum_d   = ACC_W'(cout - ONE);
        cout_d  = cout;
        err_d   = over;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_ff_rst)
    if (i_ff_rst) begin
      state_q    <= RST_STATE;
      req_dly_q  <= RST_BIT;
      pend_q     <= RST_BIT;
      cnt_q      <= '0;
      sh_seed_q  <= '0;
      sh_order_q <= '0;
      sh_mb_q    <= '0;
      sh_mr_q    <= RST_BIT;
      sh_pa_q    <= RST_BIT;
      sh_sf_q    <= RST_BIT;
      seed_q     <= '0;
      order_q    <= '0;
      mr_q       <= RST_BIT;
      pa_q       <= RST_BIT;
      sf_q       <= RST_BIT;
      sum_q      <= '0;
      cout_q     <= '0;
      err_q      <= RST_BIT;
      mrst_q     <= RST_BIT;
      busy_q     <= RST_BIT;
      done_q     <= RST_BIT;
    end else begin
      state_q    <= state_d;
      req_dly_q  <= req_s;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      sh_seed_q  <= sh_seed_d;
      sh_order_q <= sh_order_d;
      sh_mb_q    <= sh_mb_d;
      sh_mr_q    <= sh_mr_d;
      sh_pa_q    <= sh_pa_d;
      sh_sf_q    <= sh_sf_d;
      seed_q     <= seed_d;
      order_q    <= order_d;
      mr_q       <= mr_d;
      pa_q       <= pa_d;
      sf_q       <= sf_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
      mrst_q     <= state_d == FLUSH;
      busy_q     <= state_d != IDLE;
      done_q     <= done_d;
    end

  assign bus.o_seed          = seed_q;
  assign bus.o_sel_order     = order_q;
  assign bus.o_mashreseten   = mr_q;
  assign bus.o_phaseadjusten = pa_q;
  assign bus.o_sel_frac      = sf_q;
  assign bus.o_sum_sel       = sum_q;
  assign bus.o_cout_sel      = cout_q;
  assign bus.o_cfg_err       = err_q;
  assign bus.o_mash_rst      = mrst_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_upd_done      = done_q;
endmodule

// File: tb/tb_ddsm_cfg_sync.sv
// tb_ddsm_cfg_sync: schedule-based reference model plus directed and random update traffic
module tb_ddsm_cfg_sync;
  localparam int SEED_W = 12, ACC_W = 8, MB_W = 4, ORDER_W = 2, S = 2, RC = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  ddsm_cfg_sync_if #(.SEED_W(SEED_W), .ACC_W(ACC_W), .MB_W(MB_W), .ORDER_W(ORDER_W)) bus();
  ddsm_cfg_sync #(
    .SEED_W(SEED_W), .ACC_W(ACC_W), .MB_W(MB_W), .ORDER_W(ORDER_W), .SYNC_STAGES(S), .RST_CYC(RC)
  ) dut (.i_clk(clk), .i_ff_rst(rst), .bus(bus));

  int total = 0, bad = 0, cyc = 0, done_cnt = 0, mrst_cnt = 0, lat;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", nm, a, e, cyc);
    end
  endtask

  // Reference: each update is a job started at edge s, finishing at s+2(+RC if flushed)
  logic [7:0] hist = '0;
  bit act = 0, pend = 0, f = 0, arrival, idle_before;
  int s = 0, d = 0, m;
  logic [SEED_W-1:0] c_seed = '0, e_seed = '0;
  logic [ORDER_W-1:0] c_ord = '0, e_ord = '0;
  logic [MB_W-1:0] c_mb = '0;
  bit c_mr = 0, c_pa = 0, c_sf = 0;
  logic e_mr = 0, e_pa = 0, e_sf = 0, e_err = 0, e_mrst = 0, e_busy = 0, e_done = 0;
  logic [ACC_W-1:0] e_sum = '0;
  logic [ACC_W:0] e_cout = '0;

  always @(posedge clk or posedge rst)
    if (rst) begin
      hist = '0; act = 0; pend = 0; f = 0;
      e_seed = '0; e_ord = '0; e_mr = 0; e_pa = 0; e_sf = 0;
      e_sum = '0; e_cout = '0; e_err = 0; e_mrst = 0; e_busy = 0; e_done = 0;
    end else begin
      cyc++;
      hist = {hist[6:0], bus.i_upd_req};
      arrival = hist[S] && !hist[S+1];
      idle_before = !act;
      e_done = 0;
      if (idle_before && (arrival || pend)) begin
        act = 1; s = cyc; d = cyc + 1000; f = 0; pend = 0;
      end else if (arrival) pend = 1;
      if (act && cyc == s + 1) begin
        c_seed = bus.i_seed; c_ord = bus.i_sel_order; c_mb = bus.i_mash_bit;
        c_mr = bus.i_mashreseten; c_pa = bus.i_phaseadjusten; c_sf = bus.i_sel_frac;
        f = c_mr;
        d = s + 2 + (f ? RC : 0);
      end
      if (act && cyc == d) begin
        m = (int'(c_mb) > ACC_W) ? ACC_W : int'(c_mb);
        e_seed = c_seed; e_ord = c_ord; e_mr = c_mr; e_pa = c_pa; e_sf = c_sf;
        e_sum = ACC_W'((1 << m) - 1);
        e_cout = (ACC_W+1)'(1 << m);
        e_err = int'(c_mb) > ACC_W;
        e_done = 1; act = 0;
      end
      e_busy = act;
      e_mrst = act && f && cyc >= s + 1 && cyc <= s + RC;
    end

  always @(negedge clk)
    if (!rst) begin
      chk("seed", 32'(bus.o_seed), 32'(e_seed));
      chk("order", 32'(bus.o_sel_order), 32'(e_ord));
      chk("mashreseten", 32'(bus.o_mashreseten), 32'(e_mr));
      chk("phaseadj", 32'(bus.o_phaseadjusten), 32'(e_pa));
      chk("sel_frac", 32'(bus.o_sel_frac), 32'(e_sf));
      chk("sum_sel", 32'(bus.o_sum_sel), 32'(e_sum));
      chk("cout_sel", 32'(bus.o_cout_sel), 32'(e_cout));
      chk("cfg_err", 32'(bus.o_cfg_err), 32'(e_err));
      chk("mash_rst", 32'(bus.o_mash_rst), 32'(e_mrst));
      chk("busy", 32'(bus.o_busy), 32'(e_busy));
      chk("upd_done", 32'(bus.o_upd_done), 32'(e_done));
      if (bus.o_upd_done) done_cnt++;
      if (bus.o_mash_rst) mrst_cnt++;
    end

  task automatic set_cfg(input logic [SEED_W-1:0] sd, input int mb, input bit mr);
    bus.i_seed = sd;
    bus.i_mash_bit = MB_W'(mb);
    bus.i_mashreseten = mr;
    bus.i_sel_order = ORDER_W'($urandom);
    bus.i_phaseadjusten = 1'($urandom);
    bus.i_sel_frac = 1'($urandom);
  endtask

  // Issues one request and returns edges from first high sample to the done pulse
  task automatic upd(input logic [SEED_W-1:0] sd, input int mb, input bit mr, output int l);
    int n, k;
    @(negedge clk);
    set_cfg(sd, mb, mr);
    bus.i_upd_req = 1'b1;
    n = cyc + 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) bus.i_upd_req = 1'b0;
    end while (!bus.o_upd_done && k < 60);
    chk("done_seen", 32'(bus.o_upd_done), 32'd1);
    l = cyc - n;
  endtask

  task automatic wait_idle();
    int q, k;
    q = 0; k = 0;
    while (q < S + 3 && k < 300) begin
      @(negedge clk);
      k++;
      q = bus.o_busy ? 0 : q + 1;
    end
    chk("idle_reached", 32'(q >= S + 3), 32'd1);
  endtask

  initial begin
    int k;
    bus.i_upd_req = 1'b0;
    set_cfg('0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_cout", 32'(bus.o_cout_sel), 32'd0);
    chk("rst_sum", 32'(bus.o_sum_sel), 32'd0);

    mrst_cnt = 0;
    upd(12'hA5C, 5, 0, lat);
    chk("lat_noflush", 32'(lat), 32'd4);
    chk("nf_sum", 32'(bus.o_sum_sel), 32'h1F);
    chk("nf_cout", 32'(bus.o_cout_sel), 32'h020);
    chk("nf_seed", 32'(bus.o_seed), 32'hA5C);
    chk("nf_mrst_cnt", 32'(mrst_cnt), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.o_upd_done), 32'd0);
    wait_idle();

    mrst_cnt = 0;
    upd(12'h123, 3, 1, lat);
    chk("lat_flush", 32'(lat), 32'd8);
    chk("fl_mrst_low", 32'(bus.o_mash_rst), 32'd0);
    chk("fl_sum", 32'(bus.o_sum_sel), 32'h07);
    chk("fl_cout", 32'(bus.o_cout_sel), 32'h008);
    chk("fl_mrst_cnt", 32'(mrst_cnt), 32'd4);
    wait_idle();

    upd(12'h0F0, 12, 0, lat);
    chk("clamp_sum", 32'(bus.o_sum_sel), 32'hFF);
    chk("clamp_cout", 32'(bus.o_cout_sel), 32'h100);
    chk("clamp_err", 32'(bus.o_cfg_err), 32'd1);
    wait_idle();
    upd(12'h00F, 0, 0, lat);
    chk("zero_sum", 32'(bus.o_sum_sel), 32'h00);
    chk("zero_cout", 32'(bus.o_cout_sel), 32'h001);
    chk("zero_err", 32'(bus.o_cfg_err), 32'd0);
    wait_idle();

    // Four rises two cycles apart: the last three land while the first update is busy
    done_cnt = 0;
    @(negedge clk);
    set_cfg(12'h5A5, 6, 1);
    for (int i = 0; i < 4; i++) begin
      bus.i_upd_req = 1'b1;
      @(negedge clk);
      bus.i_upd_req = 1'b0;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("merge_dones", 32'(done_cnt), 32'd2);
    wait_idle();

    done_cnt = 0;
    @(negedge clk);
    set_cfg(12'hBEE, 2, 1);
    bus.i_upd_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) bus.i_upd_req = 1'b0;
    end while (!bus.o_mash_rst && k < 40);
    chk("mrst_seen", 32'(bus.o_mash_rst), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_mrst", 32'(bus.o_mash_rst), 32'd0);
    chk("ar_busy", 32'(bus.o_busy), 32'd0);
    chk("ar_seed", 32'(bus.o_seed), 32'd0);
    chk("ar_sum", 32'(bus.o_sum_sel), 32'd0);
    chk("ar_cout", 32'(bus.o_cout_sel), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_no_done", 32'(done_cnt), 32'd0);
    upd(12'h3C3, 7, 0, lat);
    chk("ar_lat", 32'(lat), 32'd4);
    chk("ar_after_sum", 32'(bus.o_sum_sel), 32'h7F);
    chk("ar_after_cout", 32'(bus.o_cout_sel), 32'h080);
    wait_idle();

    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      set_cfg(SEED_W'($urandom), $urandom_range(0, 15), 1'($urandom));
      for (int p = 0; p < $urandom_range(1, 3); p++) begin
        bus.i_upd_req = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.i_upd_req = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
